// File: rtl/dotp_pkg.sv
`default_nettype none
// =====================================================================
// dotp_pkg : shared types, defaults and width helper for dotp_seq_ctrl
// Rev 1.0
// =====================================================================
package dotp_pkg;

  localparam int BITS_NUM_DEF = 4;
  localparam int ELEMS_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } dotp_state_t;

  // Widest sum of ELEMS products of two BITS_NUM-bit unsigned values
  function automatic int dotp_out_w(input int bits, input int elems);
    return 2 * bits + $clog2(elems);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dotp_seq_ctrl_mul_addtree.sv
`default_nettype none
// =====================================================================
// mul_addtree : unsigned BITS_NUM x BITS_NUM multiplier built from summed partial products
// Rev 1.0
// =====================================================================
module mul_addtree #(
  parameter int BITS_NUM = 4
) (
  input  logic [BITS_NUM-1:0]   x,
  input  logic [BITS_NUM-1:0]   y,
  output logic [2*BITS_NUM-1:0] product
);

  logic [2*BITS_NUM-1:0] pp [BITS_NUM];

  for (genvar i = 0; i < BITS_NUM; i++) begin : g_pp
    assign pp[i] = y[i] ? ({{BITS_NUM{1'b0}}, x} << i) : '0;
  end

  always_comb begin
    product = '0;
    for (int i = 0; i < BITS_NUM; i++) begin
      product = product + pp[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dotp_seq_ctrl.sv
`default_nettype none
// =====================================================================
// dotp_seq_ctrl : sequential dot product, one shared multiplier, one element pair per cycle
// Optional DOTP_STATS_EN adds the op_count handshake counter.  Rev 1.0
// =====================================================================
module dotp_seq_ctrl
  import dotp_pkg::*;
#(
  parameter  int BITS_NUM = BITS_NUM_DEF,
  parameter  int ELEMS    = ELEMS_DEF,
  localparam int OUT_W    = dotp_out_w(BITS_NUM, ELEMS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ELEMS*BITS_NUM-1:0] a_vec,
  input  logic [ELEMS*BITS_NUM-1:0] b_vec,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          result,
  output logic                      busy
`ifdef DOTP_STATS_EN
  ,output logic [15:0]              op_count
`endif
);

  localparam int IDX_W = $clog2(ELEMS);
  localparam int PW    = 2 * BITS_NUM;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_MAC  = MAC;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [OUT_W-1:0]          acc_q, acc_d;
  logic [OUT_W-1:0]          result_q, result_d;
  logic [ELEMS*BITS_NUM-1:0] a_q, a_d;
  logic [ELEMS*BITS_NUM-1:0] b_q, b_d;

  logic [BITS_NUM-1:0]       a_elem;
  logic [BITS_NUM-1:0]       b_elem;
  logic [PW-1:0]             prod;
  logic [OUT_W-1:0]          sum;
  logic                      last_elem;

  assign a_elem    = a_q[idx_q*BITS_NUM +: BITS_NUM];
  assign b_elem    = b_q[idx_q*BITS_NUM +: BITS_NUM];
  assign sum       = acc_q + {{(OUT_W-PW){1'b0}}, prod};
  assign last_elem = (idx_q == IDX_W'(ELEMS-1));

  mul_addtree #(
    .BITS_NUM (BITS_NUM)
  ) u_mul (
    .x       (a_elem),
    .y       (b_elem),
    .product (prod)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a_vec;
          b_d     = b_vec;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = sum;
        if (last_elem) begin
          result_d = sum;
          idx_d    = '0;
          state_d  = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_MAC) || (state_q == ST_DONE);
  assign result    = result_q;

`ifdef DOTP_STATS_EN
  logic [15:0] op_count_q, op_count_d;

  // Free-running handshake count, wraps naturally at 16 bits
  always_comb begin
    op_count_d = op_count_q;
    if (out_valid && out_ready) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dotp_seq_ctrl.sv
`default_nettype none
// =====================================================================
// tb_dotp_seq_ctrl : scoreboard bench for dotp_seq_ctrl
// Rev 1.0
// =====================================================================
module tb_dotp_seq_ctrl;

  localparam int BITS_NUM = 4;
  localparam int ELEMS    = 4;
  localparam int OUT_W    = 10;
  localparam int VW       = ELEMS * BITS_NUM;
  localparam int BOUND    = 50;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [VW-1:0]     a_vec;
  logic [VW-1:0]     b_vec;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  result;
  logic              busy;
`ifdef DOTP_STATS_EN
  logic [15:0]       op_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [OUT_W-1:0] exp_q[$];

  dotp_seq_ctrl #(
    .BITS_NUM (BITS_NUM),
    .ELEMS    (ELEMS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_vec     (a_vec),
    .b_vec     (b_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
`ifdef DOTP_STATS_EN
    ,.op_count (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [OUT_W-1:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
    int s;
    s = 0;
    for (int i = 0; i < ELEMS; i++) s += int'(a[i*BITS_NUM +: BITS_NUM]) * int'(b[i*BITS_NUM +: BITS_NUM]);
    return OUT_W'(s);
  endfunction

  // Present a pair, wait (bounded) for acceptance, push its expected sum; k = accept edge
  task automatic accept_pair(input logic [VW-1:0] a, input logic [VW-1:0] b, input bit hold, output int k);
    int n;
    @(negedge clk);
    a_vec = a; b_vec = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < BOUND) begin @(negedge clk); n++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    exp_q.push_back(dot(a, b));
    @(posedge clk); #1;
    k = cyc;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (n < BOUND) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
      n++;
    end
  endtask

  task automatic test_reset;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
`ifdef DOTP_STATS_EN
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
`endif
  endtask

  // Run one transaction with out_ready=1 and check the result and latency
  task automatic run_one(input string name, input logic [VW-1:0] a, input logic [VW-1:0] b);
    int k;
    bit ok;
    logic [OUT_W-1:0] e;
    out_ready = 1'b1;
    accept_pair(a, b, 1'b0, k);
    wait_out(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s_timeout: out_valid never rose", name);
    end else begin
      if (result !== e) begin errors++; $display("FAIL %s_result: got %0d want %0d", name, result, e); end
      checks++;
      if (cyc - k != ELEMS) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, cyc - k, ELEMS); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    run_one("basic", {4'd4, 4'd3, 4'd2, 4'd1}, {4'd8, 4'd7, 4'd6, 4'd5});
  endtask

  task automatic test_boundary;
    run_one("max", {VW{1'b1}}, {VW{1'b1}});
    run_one("zero_a", '0, {4'd9, 4'd15, 4'd3, 4'd7});
    checks++;
    if (dot({VW{1'b1}}, {VW{1'b1}}) !== 10'h384 || dot({4'd4, 4'd3, 4'd2, 4'd1}, {4'd8, 4'd7, 4'd6, 4'd5}) !== 10'h046) begin
      errors++; $display("FAIL model_ref: got %0d want 900", dot({VW{1'b1}}, {VW{1'b1}}));
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 4; t++) begin
      run_one("random", VW'($urandom), VW'($urandom));
    end
  endtask

  task automatic test_backpressure;
    int k;
    bit ok;
    logic [OUT_W-1:0] e;
    out_ready = 1'b0;
    accept_pair({4'd2, 4'd9, 4'd11, 4'd6}, {4'd13, 4'd1, 4'd5, 4'd10}, 1'b0, k);
    wait_out(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: out_valid never rose"); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== e || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%0b result=%0d in_ready=%0b busy=%0b want 1/%0d/0/1",
                 i, out_valid, result, in_ready, busy, e);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    int k1, k2, n;
    bit ok;
    logic [OUT_W-1:0] e;
    logic [VW-1:0] a2, b2;
    out_ready = 1'b1;
    a2 = {4'd1, 4'd1, 4'd1, 4'd1};
    b2 = {4'd3, 4'd3, 4'd3, 4'd3};
    accept_pair({4'd4, 4'd3, 4'd2, 4'd1}, {4'd8, 4'd7, 4'd6, 4'd5}, 1'b1, k1);
    // in_valid stays high with new data while the first pair is in MAC
    a_vec = a2; b_vec = b2;
    wait_out(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || result !== e) begin errors++; $display("FAIL b2b_first: got %0d want %0d", result, e); end
    n = 0;
    while (!in_ready && n < BOUND) begin @(negedge clk); n++; end
    exp_q.push_back(dot(a2, b2));
    @(posedge clk); #1;
    k2 = cyc;
    in_valid = 1'b0;
    checks++;
    if (k2 - k1 != ELEMS + 2) begin errors++; $display("FAIL b2b_accept_edge: got %0d want %0d", k2 - k1, ELEMS + 2); end
    wait_out(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || result !== e || cyc - k2 != ELEMS) begin
      errors++; $display("FAIL b2b_second: got %0d lat %0d want %0d lat %0d", result, cyc - k2, e, ELEMS);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mac;
    int k;
    logic [OUT_W-1:0] discard;
    out_ready = 1'b1;
    accept_pair({VW{1'b1}}, {VW{1'b1}}, 1'b0, k);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %0b want 1", busy); end
    rst_n = 1'b0;
    #1;
    discard = exp_q.pop_back();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL rst_mid_mac: in_ready=%0b out_valid=%0b busy=%0b result=%0d want 1/0/0/0 (dropped %0d)",
               in_ready, out_valid, busy, result, discard);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_one("after_rst", {4'd0, 4'd1, 4'd0, 4'd2}, {4'd5, 4'd4, 4'd3, 4'd1});
  endtask

`ifdef DOTP_STATS_EN
  task automatic test_stats;
    run_one("stats_a", {4'd1, 4'd2, 4'd3, 4'd4}, {4'd1, 4'd1, 4'd1, 4'd1});
    run_one("stats_b", {4'd5, 4'd2, 4'd7, 4'd4}, {4'd2, 4'd1, 4'd2, 4'd1});
    run_one("stats_c", {4'd9, 4'd9, 4'd9, 4'd9}, {4'd1, 4'd0, 4'd1, 4'd0});
    checks++;
    if (op_count !== 16'd3) begin errors++; $display("FAIL stats_count3: got %0d want 3", op_count); end
    @(negedge clk);
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    checks++;
    if (op_count !== 16'hFFFF) begin errors++; $display("FAIL stats_preload: got %h want ffff", op_count); end
    run_one("stats_wrap", {4'd1, 4'd1, 4'd1, 4'd1}, {4'd1, 4'd1, 4'd1, 4'd1});
    checks++;
    if (op_count !== 16'd0) begin errors++; $display("FAIL stats_wrap: got %h want 0000", op_count); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_vec = '0; b_vec = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_boundary();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mac();
`ifdef DOTP_STATS_EN
    test_stats();
`endif
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
